// File: rtl/ted_pio_out_pulse.sv
// Avalon-MM output PIO with atomic bit set/clear and a timed pulse engine that inverts masked bits.
// Defining TED_PIO_IRQ_EN adds the sticky STATUS.done flag and drives irq from it.
module ted_pio_out_pulse #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           CNT_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_PULSE  = 3'd3;
    localparam logic [2:0] ADDR_PLEN   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] data, data_nxt;
    logic [DATA_WIDTH-1:0] mask, mask_nxt;
    logic [DATA_WIDTH-1:0] out_port_nxt;
    logic [CNT_WIDTH-1:0]  plen, plen_nxt;
    logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
    logic                  overrun, overrun_nxt;
    logic                  done;

    logic                  wr_c;
    logic                  pulse_wr_c;
    logic                  status_wr_c;
    logic                  pulse_end_c;
    logic                  busy_c;
    logic [DATA_WIDTH-1:0] wd_data_c;
    logic [CNT_WIDTH-1:0]  wd_cnt_c;
    logic [CNT_WIDTH-1:0]  plen_eff_c;
    logic                  unused_wd;

    assign wr_c        = chipselect & ~write_n;
    assign pulse_wr_c  = wr_c && (address == ADDR_PULSE);
    assign status_wr_c = wr_c && (address == ADDR_STATUS);
    assign busy_c      = (state == ST_PULSE);
    assign wd_data_c   = writedata[DATA_WIDTH-1:0];
    assign wd_cnt_c    = writedata[CNT_WIDTH-1:0];
    // A programmed length of zero still yields a one-cycle pulse.
    assign plen_eff_c  = (plen == '0) ? CNT_WIDTH'(1) : plen;
    assign unused_wd   = ^writedata;

    // State and register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            data     <= RESET_VALUE;
            mask     <= '0;
            plen     <= CNT_WIDTH'(1);
            cnt      <= '0;
            overrun  <= 1'b0;
            out_port <= RESET_VALUE;
        end else begin
            state    <= state_nxt;
            data     <= data_nxt;
            mask     <= mask_nxt;
            plen     <= plen_nxt;
            cnt      <= cnt_nxt;
            overrun  <= overrun_nxt;
            out_port <= out_port_nxt;
        end
    end

    // Register writes, pulse sequencing and next output value.
    always_comb begin
        state_nxt   = state;
        data_nxt    = data;
        mask_nxt    = mask;
        plen_nxt    = plen;
        cnt_nxt     = cnt;
        overrun_nxt = overrun;
        pulse_end_c = 1'b0;

        if (wr_c) begin
            case (address)
                ADDR_DATA:   data_nxt = wd_data_c;
                ADDR_SET:    data_nxt = data | wd_data_c;
                ADDR_CLEAR:  data_nxt = data & ~wd_data_c;
                ADDR_PLEN:   plen_nxt = wd_cnt_c;
                ADDR_STATUS: if (writedata[1]) overrun_nxt = 1'b0;
                default:     ;
            endcase
        end

        case (state)
            ST_IDLE: begin
                if (pulse_wr_c) begin
                    state_nxt = ST_PULSE;
                    mask_nxt  = wd_data_c;
                    cnt_nxt   = plen_eff_c;
                end
            end
            ST_PULSE: begin
                // A pulse request while one is running is dropped and flagged, even on the last cycle.
                if (pulse_wr_c) overrun_nxt = 1'b1;
                if (cnt == CNT_WIDTH'(1)) begin
                    state_nxt   = ST_IDLE;
                    mask_nxt    = '0;
                    cnt_nxt     = '0;
                    pulse_end_c = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_WIDTH'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        out_port_nxt = data_nxt ^ mask_nxt;
    end

`ifdef TED_PIO_IRQ_EN
    logic done_nxt;

    // Sticky pulse-done flag; a completing pulse beats a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) done <= 1'b0;
        else       done <= done_nxt;
    end

    always_comb begin
        done_nxt = done;
        if (status_wr_c && writedata[2]) done_nxt = 1'b0;
        if (pulse_end_c)                 done_nxt = 1'b1;
    end

    assign irq = done;
`else
    logic unused_irq_src;

    assign done           = 1'b0;
    assign irq            = 1'b0;
    assign unused_irq_src = status_wr_c ^ pulse_end_c;
`endif

    // Zero-latency read mux.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data);
            ADDR_PULSE:  readdata = 32'(mask);
            ADDR_PLEN:   readdata = 32'(plen);
            ADDR_STATUS: readdata = {29'd0, done, overrun, busy_c};
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ted_pio_out_pulse.sv
// Bench for ted_pio_out_pulse: directed vector table, mid-pulse reset sequence, and random traffic
// checked against a cycle-indexed reference model.
module tb_ted_pio_out_pulse;

    localparam logic [31:0] RV = 32'h0000_00A5;
`ifdef TED_PIO_IRQ_EN
    localparam logic [31:0] DN = 32'h4;
`else
    localparam logic [31:0] DN = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ted_pio_out_pulse #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (16),
        .RESET_VALUE(32'h0000_00A5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_out;
        logic [31:0] exp_stat;
    } vec_t;

    vec_t vecs[$];

    // Reference model: a pulse is described by the absolute edge number at which it ends.
    logic [31:0] m_data, m_mask;
    logic [15:0] m_plen;
    logic        m_busy, m_ovr, m_done;
    longint      cyc, m_end;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] a, input logic [31:0] d);
        chipselect = we;
        write_n    = ~we;
        address    = a;
        writedata  = d;
    endtask

    task automatic add(input logic we, input logic [2:0] a, input logic [31:0] d,
                       input logic [31:0] eo, input logic [31:0] es);
        vec_t v;
        v.we = we; v.addr = a; v.wd = d; v.exp_out = eo; v.exp_stat = es;
        vecs.push_back(v);
    endtask

    task automatic m_reset();
        m_data = RV; m_mask = '0; m_plen = 16'd1;
        m_busy = 1'b0; m_ovr = 1'b0; m_done = 1'b0;
        cyc = 0; m_end = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_data;
            3'd3:    return m_mask;
            3'd4:    return 32'(m_plen);
            3'd5:    return ((DN != 0 && m_done) ? 32'h4 : 32'h0) | (m_ovr ? 32'h2 : 32'h0)
                            | (m_busy ? 32'h1 : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step(input logic we, input logic [2:0] a, input logic [31:0] d);
        logic ending;
        cyc++;
        ending = m_busy && (cyc == m_end);
        if (we) begin
            case (a)
                3'd0: m_data = d;
                3'd1: m_data = m_data | d;
                3'd2: m_data = m_data & ~d;
                3'd3: begin
                    if (m_busy) m_ovr = 1'b1;
                    else begin
                        m_mask = d;
                        m_busy = 1'b1;
                        m_end  = cyc + ((m_plen == 16'd0) ? 1 : longint'(m_plen));
                    end
                end
                3'd4: m_plen = d[15:0];
                3'd5: begin
                    if (d[1]) m_ovr = 1'b0;
                    if (d[2]) m_done = 1'b0;
                end
                default: ;
            endcase
        end
        if (ending) begin
            m_mask = '0;
            m_busy = 1'b0;
            if (DN != 0) m_done = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 3'd0, 32'h0);

        // Reset values, held and after release.
        @(negedge clk);
        chk("rst out", out_port, RV);
        chk("rst data", readdata, RV);
        drive(1'b0, 3'd5, 32'h0); #1;
        chk("rst stat", readdata, 32'h0);
        drive(1'b0, 3'd4, 32'h0); #1;
        chk("rst plen", readdata, 32'h1);
        chk("rst irq", 32'(irq), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel out", out_port, RV);

        // Directed one-cycle-per-entry table.
        add(1, 3'd0, 32'h0000_FF00, 32'h0000_FF00, 0);
        add(1, 3'd1, 32'h0000_000F, 32'h0000_FF0F, 0);
        add(1, 3'd2, 32'h0000_0F00, 32'h0000_F00F, 0);
        add(1, 3'd0, 32'h0,         32'h0,         0);
        add(1, 3'd4, 32'd3,         32'h0,         0);
        add(1, 3'd3, 32'h1,         32'h1,         1);
        add(0, 3'd0, 32'h0,         32'h1,         1);
        add(0, 3'd0, 32'h0,         32'h1,         1);
        add(0, 3'd0, 32'h0,         32'h0,         DN);
        add(1, 3'd5, 32'h4,         32'h0,         0);
        add(1, 3'd4, 32'd0,         32'h0,         0);
        add(1, 3'd3, 32'h8000_0000, 32'h8000_0000, 1);
        add(0, 3'd0, 32'h0,         32'h0,         DN);
        add(1, 3'd5, 32'h4,         32'h0,         0);
        add(1, 3'd4, 32'd10,        32'h0,         0);
        add(1, 3'd3, 32'h3,         32'h3,         1);
        add(0, 3'd0, 32'h0,         32'h3,         1);
        add(0, 3'd0, 32'h0,         32'h3,         1);
        add(1, 3'd3, 32'hC,         32'h3,         3);
        add(1, 3'd5, 32'h2,         32'h3,         1);
        add(1, 3'd0, 32'h1,         32'h2,         1);
        for (int k = 0; k < 4; k++) add(0, 3'd0, 32'h0, 32'h2, 1);
        add(0, 3'd0, 32'h0,         32'h1,         DN);
        add(1, 3'd5, 32'h4,         32'h1,         0);
        add(1, 3'd4, 32'd2,         32'h1,         0);
        add(1, 3'd3, 32'h0,         32'h1,         1);
        add(0, 3'd0, 32'h0,         32'h1,         1);
        add(1, 3'd3, 32'h5,         32'h1,         DN | 32'h2);
        add(1, 3'd5, 32'h6,         32'h1,         0);

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wd);
            @(negedge clk);
            drive(1'b0, 3'd5, 32'h0); #1;
            chk($sformatf("vec%0d out", i), out_port, vecs[i].exp_out);
            chk($sformatf("vec%0d stat", i), readdata, vecs[i].exp_stat);
            chk($sformatf("vec%0d irq", i), 32'(irq), (vecs[i].exp_stat & 32'h4) >> 2);
        end

        // Reset asserted during a 5-cycle pulse, then a fresh pulse.
        drive(1'b1, 3'd4, 32'd5); @(negedge clk);
        drive(1'b1, 3'd3, 32'hF0); @(negedge clk);
        drive(1'b0, 3'd5, 32'h0); #1;
        chk("mid out1", out_port, 32'hF1);
        @(negedge clk);
        chk("mid out2", out_port, 32'hF1);
        reset = 1'b1; #1;
        chk("mid rst out", out_port, RV);
        chk("mid rst stat", readdata, 32'h0);
        chk("mid rst irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 3'd3, 32'h1); @(negedge clk);
        drive(1'b0, 3'd5, 32'h0); #1;
        chk("post out pulse", out_port, 32'hA4);
        chk("post busy", readdata, 32'h1);
        @(negedge clk);
        chk("post out restore", out_port, RV);
        chk("post stat", readdata, DN);

        // Random traffic against the model.
        reset = 1'b1;
        drive(1'b0, 3'd0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        we;
            logic [2:0]  a;
            logic [31:0] d;
            chk("rnd out", out_port, m_data ^ m_mask);
            chk("rnd irq", 32'(irq), 32'(m_done));
            we = 1'($urandom_range(0, 1));
            a  = 3'($urandom_range(0, 7));
            d  = $urandom();
            if (a == 3'd4) d = 32'($urandom_range(0, 6));
            if (a == 3'd3 && $urandom_range(0, 3) == 0) d = 32'h0;
            drive(we, a, d); #1;
            chk($sformatf("rnd rd a%0d", a), readdata, m_read(a));
            m_step(we, a, d);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
